// File: rtl/fpu_pkg.sv
// Opcode map, state encoding and per-op attribute helpers shared by the FP issue controller.
package fpu_pkg;

  localparam int unsigned OP_FADD_D  = 32'h00;
  localparam int unsigned OP_FSUB_D  = 32'h01;
  localparam int unsigned OP_FMUL_D  = 32'h02;
  localparam int unsigned OP_FDIV_D  = 32'h03;
  localparam int unsigned OP_FSQRT_D = 32'h04;
  localparam int unsigned OP_FCVT_LD = 32'h05;
  localparam int unsigned OP_FCVT_DL = 32'h06;
  localparam int unsigned OP_FMV_XD  = 32'h07;
  localparam int unsigned OP_FMV_DX  = 32'h08;
  localparam int unsigned OP_FADD_S  = 32'h09;
  localparam int unsigned OP_FSUB_S  = 32'h0A;
  localparam int unsigned OP_FMUL_S  = 32'h0B;
  localparam int unsigned OP_FDIV_S  = 32'h0C;
  localparam int unsigned OP_FSQRT_S = 32'h0D;

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_WB} state_e;
  typedef enum logic [1:0] {LAT_ADD, LAT_MUL, LAT_DIV, LAT_CVT} lat_class_e;

  function automatic lat_class_e op_latency_class(input int unsigned op);
    case (op)
      OP_FADD_D, OP_FSUB_D, OP_FADD_S, OP_FSUB_S:   return LAT_ADD;
      OP_FMUL_D, OP_FMUL_S:                         return LAT_MUL;
      OP_FDIV_D, OP_FSQRT_D, OP_FDIV_S, OP_FSQRT_S: return LAT_DIV;
      default:                                      return LAT_CVT;
    endcase
  endfunction

  function automatic logic op_is_single(input int unsigned op);
    return (op >= OP_FADD_S) && (op <= OP_FSQRT_S);
  endfunction

  // Only the FP->integer moves/conversions target the integer file.
  function automatic logic op_to_fpr(input int unsigned op);
    return !((op == OP_FCVT_LD) || (op == OP_FMV_XD));
  endfunction

  function automatic logic op_is_legal(input int unsigned op);
    return op <= OP_FSQRT_S;
  endfunction

endpackage

// File: rtl/fpu_op_decode.sv
// Combinational opcode decode: latency class, single-precision, destination file and legality.
module fpu_op_decode
  import fpu_pkg::*;
#(
  parameter int OP_LEN = 5
) (
  input  logic [OP_LEN-1:0] op,
  output lat_class_e        lat_class,
  output logic              is_single,
  output logic              to_fpr,
  output logic              legal
);

  logic [31:0] op_ext;

  assign op_ext    = 32'(op);
  assign lat_class = op_latency_class(op_ext);
  assign is_single = op_is_single(op_ext);
  assign to_fpr    = op_to_fpr(op_ext);
  assign legal     = op_is_legal(op_ext);

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Holds FPU operands stable for a fixed per-op latency, then NaN-boxes and presents a writeback.
// Accepts one request only in IDLE; the writeback is held until wb_ready.
module fpu_issue_ctrl
  import fpu_pkg::*;
#(
  parameter int BUS_WIDTH = 64,
  parameter int OP_LEN    = 5,
  parameter int ADD_LAT   = 2,
  parameter int MUL_LAT   = 3,
  parameter int DIV_LAT   = 8,
  parameter int CVT_LAT   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [OP_LEN-1:0]    req_op,
  input  logic [BUS_WIDTH-1:0] req_rs1_val,
  input  logic [BUS_WIDTH-1:0] req_rs2_val,
  input  logic [4:0]           req_rd,
  output logic [BUS_WIDTH-1:0] fpu_in1,
  output logic [BUS_WIDTH-1:0] fpu_in2,
  output logic [OP_LEN-1:0]    fpu_op,
  input  logic [BUS_WIDTH-1:0] fpu_out,
  output logic                 wb_valid,
  input  logic                 wb_ready,
  output logic [BUS_WIDTH-1:0] wb_data,
  output logic [4:0]           wb_rd,
  output logic                 wb_to_fpr,
  output logic                 busy,
  output logic                 illegal
);

  localparam int MAX_AM  = (ADD_LAT > MUL_LAT) ? ADD_LAT : MUL_LAT;
  localparam int MAX_DC  = (DIV_LAT > CVT_LAT) ? DIV_LAT : CVT_LAT;
  localparam int MAX_LAT = (MAX_AM > MAX_DC) ? MAX_AM : MAX_DC;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BUS_WIDTH-1:0] fpu_in1_q, fpu_in1_d, fpu_in2_q, fpu_in2_d;
  logic [OP_LEN-1:0]    fpu_op_q, fpu_op_d;
  logic                 wb_valid_q, wb_valid_d;
  logic [BUS_WIDTH-1:0] wb_data_q, wb_data_d;
  logic [4:0]           wb_rd_q, wb_rd_d;
  logic                 wb_to_fpr_q, wb_to_fpr_d;
  logic                 illegal_q, illegal_d;

  // In IDLE the decoder looks at the incoming request; otherwise at the op in flight.
  logic [OP_LEN-1:0] dec_op;
  lat_class_e        dec_class;
  logic              dec_single, dec_to_fpr, dec_legal;
  logic [CNT_W-1:0]  cnt_init;

  assign dec_op = (state_q == ST_IDLE) ? req_op : fpu_op_q;

  fpu_op_decode #(.OP_LEN(OP_LEN)) u_dec (
    .op        (dec_op),
    .lat_class (dec_class),
    .is_single (dec_single),
    .to_fpr    (dec_to_fpr),
    .legal     (dec_legal)
  );

  always_comb begin
    cnt_init = CNT_W'(CVT_LAT - 1);
    case (dec_class)
      LAT_ADD: cnt_init = CNT_W'(ADD_LAT - 1);
      LAT_MUL: cnt_init = CNT_W'(MUL_LAT - 1);
      LAT_DIV: cnt_init = CNT_W'(DIV_LAT - 1);
      default: cnt_init = CNT_W'(CVT_LAT - 1);
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    fpu_in1_d   = fpu_in1_q;
    fpu_in2_d   = fpu_in2_q;
    fpu_op_d    = fpu_op_q;
    wb_valid_d  = wb_valid_q;
    wb_data_d   = wb_data_q;
    wb_rd_d     = wb_rd_q;
    wb_to_fpr_d = wb_to_fpr_q;
    illegal_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (dec_legal) begin
            fpu_in1_d = req_rs1_val;
            fpu_in2_d = req_rs2_val;
            fpu_op_d  = req_op;
            wb_rd_d   = req_rd;
            cnt_d     = cnt_init;
            state_d   = ST_EXEC;
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      ST_EXEC: begin
        if (cnt_q == '0) begin
          wb_data_d   = dec_single ? {{(BUS_WIDTH-32){1'b1}}, fpu_out[31:0]} : fpu_out;
          wb_to_fpr_d = dec_to_fpr;
          wb_valid_d  = 1'b1;
          state_d     = ST_WB;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_WB: begin
        if (wb_ready) begin
          wb_valid_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      fpu_in1_q   <= '0;
      fpu_in2_q   <= '0;
      fpu_op_q    <= '0;
      wb_valid_q  <= 1'b0;
      wb_data_q   <= '0;
      wb_rd_q     <= '0;
      wb_to_fpr_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fpu_in1_q   <= fpu_in1_d;
      fpu_in2_q   <= fpu_in2_d;
      fpu_op_q    <= fpu_op_d;
      wb_valid_q  <= wb_valid_d;
      wb_data_q   <= wb_data_d;
      wb_rd_q     <= wb_rd_d;
      wb_to_fpr_q <= wb_to_fpr_d;
      illegal_q   <= illegal_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign fpu_in1   = fpu_in1_q;
  assign fpu_in2   = fpu_in2_q;
  assign fpu_op    = fpu_op_q;
  assign wb_valid  = wb_valid_q;
  assign wb_data   = wb_data_q;
  assign wb_rd     = wb_rd_q;
  assign wb_to_fpr = wb_to_fpr_q;
  assign illegal   = illegal_q;

endmodule
